// File: rtl/loader_pkg.sv
// +----------------------------------------------------------------------+
// | loader_pkg : shared state encoding and frame constants for the loader |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6,
    ERROR = 3'd7
  } loader_state_t;

  localparam logic [7:0] c_START_BYTE = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/program_loader_byte_timer.sv
// +----------------------------------------------------------------------+
// | byte_timer : inter-byte idle counter, flags when the gap is too long  |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module byte_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int c_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [c_WIDTH-1:0] r_count;

  // Saturates at the last value so a stalled count never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_LAST)) begin
      r_count <= r_count + c_WIDTH'(1);
    end
  end

  assign expired = enable && !clear && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// +----------------------------------------------------------------------+
// | program_loader : streams a checksummed byte frame into the text RAM   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module program_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 8,
  parameter int         DATA_WIDTH     = 12,
  parameter logic [7:0] START_BYTE     = c_START_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  prog_write,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [DATA_WIDTH-1:0] prog_cmd,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int c_CW = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

  loader_state_t         r_state;
  loader_state_t         w_next_state;
  logic [7:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [7:0]            r_checksum;
  logic [ADDR_WIDTH-1:0] r_prog_addr;
  logic [DATA_WIDTH-1:0] r_prog_cmd;
  logic                  r_core_hold;
  logic                  r_load_done;
  logic                  r_load_error;
  logic                  w_accept;
  logic                  w_timer_en;
  logic                  w_timeout;
  logic                  w_last;
  logic                  w_is_start;
  logic [c_CW-1:0]       w_index_inc;

  assign w_accept    = rx_valid && rx_ready;
  assign w_is_start  = (rx_data == START_BYTE);
  assign w_index_inc = c_CW'(r_index) + c_CW'(1);
  assign w_last      = (w_index_inc == c_CW'(r_count));

  byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_accept),
    .enable (w_timer_en),
    .expired(w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    rx_ready     = 1'b1;
    w_timer_en   = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (w_accept && w_is_start) w_next_state = COUNT;
      end
      COUNT: begin
        w_timer_en = 1'b1;
        if (w_accept)       w_next_state = (rx_data == 8'd0) ? ERROR : LO;
        else if (w_timeout) w_next_state = ERROR;
      end
      LO: begin
        w_timer_en = 1'b1;
        if (w_accept)       w_next_state = HI;
        else if (w_timeout) w_next_state = ERROR;
      end
      HI: begin
        w_timer_en = 1'b1;
        if (w_accept)       w_next_state = WRITE;
        else if (w_timeout) w_next_state = ERROR;
      end
      WRITE: begin
        rx_ready     = 1'b0;
        w_next_state = w_last ? CHECK : LO;
      end
      CHECK: begin
        w_timer_en = 1'b1;
        if (w_accept)       w_next_state = (rx_data == r_checksum) ? DONE : ERROR;
        else if (w_timeout) w_next_state = ERROR;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= '0;
      r_index      <= '0;
      r_checksum   <= '0;
      r_prog_addr  <= '0;
      r_prog_cmd   <= '0;
      r_core_hold  <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_accept && w_is_start) begin
            r_core_hold  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_checksum   <= '0;
            r_index      <= '0;
          end
        end
        COUNT: begin
          if (w_accept) r_count <= rx_data;
        end
        LO: begin
          if (w_accept) begin
            r_prog_cmd[7:0] <= rx_data;
            r_checksum      <= r_checksum ^ rx_data;
          end
        end
        HI: begin
          // Bits above the instruction width are dropped but still checksummed.
          if (w_accept) begin
            r_prog_cmd[DATA_WIDTH-1:8] <= rx_data[DATA_WIDTH-9:0];
            r_checksum                 <= r_checksum ^ rx_data;
            r_prog_addr                <= r_index;
          end
        end
        WRITE: begin
          r_index <= r_index + ADDR_WIDTH'(1);
        end
        CHECK: begin
          if (w_accept && (rx_data == r_checksum)) begin
            r_load_done <= 1'b1;
            r_core_hold <= 1'b0;
          end
        end
        default: ;
      endcase
      // Every path into ERROR flags the failure; core_hold is left asserted.
      if ((w_next_state == ERROR) && (r_state != ERROR)) r_load_error <= 1'b1;
    end
  end

  assign prog_write = (r_state == WRITE);
  assign prog_addr  = r_prog_addr;
  assign prog_cmd   = r_prog_cmd;
  assign core_hold  = r_core_hold;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// +----------------------------------------------------------------------+
// | tb_program_loader : scoreboard bench for program_loader frame loading |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_write;
  logic [7:0]  prog_addr;
  logic [11:0] prog_cmd;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] cmd;
  } wr_t;

  wr_t exp_q[$];
  wr_t r_exp;
  int  n_checks = 0;
  int  n_errors = 0;
  int  k;

  always #5 clk = ~clk;

  program_loader #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (12),
    .START_BYTE    (8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .prog_write(prog_write),
    .prog_addr (prog_addr),
    .prog_cmd  (prog_cmd),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [11:0] c);
    wr_t e;
    e.addr = a;
    e.cmd  = c;
    exp_q.push_back(e);
  endtask

  // Presents a byte and returns 1ns after the edge on which it was taken.
  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_stuck_low", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   rx_ready,   1);
    check({tag, "_prog_write"}, prog_write, 0);
    check({tag, "_prog_addr"},  prog_addr,  0);
    check({tag, "_prog_cmd"},   prog_cmd,   0);
    check({tag, "_core_hold"},  core_hold,  0);
    check({tag, "_load_done"},  load_done,  0);
    check({tag, "_load_error"}, load_error, 0);
  endtask

  // Monitor: rx_ready must drop exactly during write cycles, and each write
  // must match the next expected (addr, cmd) in order.
  always @(negedge clk) begin
    if (reset) begin
      check("rx_ready_vs_write", rx_ready, !prog_write);
      if (prog_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          r_exp = exp_q.pop_front();
          check("wr_addr", prog_addr, r_exp.addr);
          check("wr_cmd",  prog_cmd,  r_exp.cmd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b1;
    idle(2);

    // Good frame: 0x11^0x0A^0x22^0x0B = 0x32
    expect_wr(8'd0, 12'hA11);
    expect_wr(8'd1, 12'hB22);
    send(8'hA5); send(8'h02); send(8'h11); send(8'h0A);
    send(8'h22); send(8'h0B); send(8'h32);
    idle(2);
    check("t1_load_done",  load_done,  1);
    check("t1_core_hold",  core_hold,  0);
    check("t1_load_error", load_error, 0);
    check("t1_addr_hold",  prog_addr,  1);
    check("t1_cmd_hold",   prog_cmd,   12'hB22);
    check("t1_q_empty",    exp_q.size(), 0);

    // Same frame, wrong checksum: writes still land, frame fails.
    expect_wr(8'd0, 12'hA11);
    expect_wr(8'd1, 12'hB22);
    send(8'hA5); send(8'h02); send(8'h11); send(8'h0A);
    send(8'h22); send(8'h0B); send(8'h12);
    idle(2);
    check("t2_load_error", load_error, 1);
    check("t2_core_hold",  core_hold,  1);
    check("t2_load_done",  load_done,  0);
    check("t2_q_empty",    exp_q.size(), 0);
    send(8'hA5);
    check("t2_err_cleared", load_error, 0);
    check("t2_hold_kept",   core_hold,  1);

    // Zero word count
    send(8'h00);
    idle(3);
    check("t3_load_error", load_error, 1);
    check("t3_core_hold",  core_hold,  1);
    check("t3_q_empty",    exp_q.size(), 0);

    // Timeout after the low byte of the only word
    send(8'hA5); send(8'h01); send(8'h11);
    rx_valid = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (load_error) break;
    end
    check("t4_timeout_cycles", k, 16);
    check("t4_core_hold",      core_hold, 1);
    check("t4_q_empty",        exp_q.size(), 0);

    // Back-to-back, START_BYTE as data, unused high bits in checksum.
    // 0x01^0x0F^0xFF^0xFE^0xA5^0x0C = 0xA6
    expect_wr(8'd0, 12'hF01);
    expect_wr(8'd1, 12'hEFF);
    expect_wr(8'd2, 12'hCA5);
    send(8'hA5); send(8'h03);
    send(8'h01); send(8'h0F);
    send(8'hFF); send(8'hFE);
    send(8'hA5); send(8'h0C);
    send(8'hA6);
    idle(2);
    check("t5_load_done",  load_done,  1);
    check("t5_load_error", load_error, 0);
    check("t5_core_hold",  core_hold,  0);
    check("t5_q_empty",    exp_q.size(), 0);

    // Asynchronous reset in the middle of a frame
    send(8'hA5); send(8'h02); send(8'h11);
    rx_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_vals("t6_midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    // 0x34^0x05 = 0x31
    expect_wr(8'd0, 12'h534);
    send(8'hA5); send(8'h01); send(8'h34); send(8'h05); send(8'h31);
    idle(2);
    check("t6_load_done",  load_done,  1);
    check("t6_core_hold",  core_hold,  0);
    check("t6_load_error", load_error, 0);
    check("t6_q_empty",    exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
